// File: rtl/vend_coin_sched_pkg.sv
// Shared coin codes, FSM output bit positions and the scheduler state type
// for the vending coin scheduler.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  localparam int VM_DISP  = 1;
  localparam int VM_CHG   = 0;
  localparam int CREDIT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    ABORT
  } vend_state_t;

  function automatic logic coin_valid(input logic [1:0] code);
    return (code == COIN_HALF) || (code == COIN_ONE);
  endfunction

  // Credit contributed by a coin, in half units.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_HALF: return CREDIT_W'(1);
      COIN_ONE:  return CREDIT_W'(2);
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap-around; ptr moves
// past the winner only when adv is pulsed.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            slot;

  // NOTE: every variable gets a default before the search loop so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    slot  = 0;
    for (int k = 0; k < N; k++) begin
      slot = (int'(ptr) + k) % N;
      if (en && !found && req[slot]) begin
        found       = 1'b1;
        grant[slot] = 1'b1;
        idx         = slot[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/vend_coin_sched.sv
// Coin scheduler in front of the 1.5-unit vending FSM: arbitrates slots,
// serialises coins, decodes dispense/change, tracks stock, aborts on timeout.
module vend_coin_sched
  import vend_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SLOTS-1:0]   coin_req,
  input  logic [2*N_SLOTS-1:0] coin_val,
  input  logic                 restock,
  input  logic [1:0]           vm_out,
  output logic [N_SLOTS-1:0]   coin_ack,
  output logic [N_SLOTS-1:0]   coin_rej,
  output logic [1:0]           vm_in,
  output logic                 vm_rst,
  output logic [N_SLOTS-1:0]   dispense,
  output logic [N_SLOTS-1:0]   change,
  output logic [N_SLOTS-1:0]   refund,
  output logic [1:0]           refund_amt,
  output logic [STOCK_W-1:0]   stock,
  output logic                 sold_out
);

  localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  vend_state_t           state;
  logic                  owner_vld;
  logic [IW-1:0]         owner;
  logic [CREDIT_W-1:0]   credit;
  logic [TW-1:0]         tmo_cnt;
  logic [N_SLOTS-1:0]    ack_q;
  logic [N_SLOTS-1:0]    rej_q;

  logic [N_SLOTS-1:0]    owner_mask;
  logic [N_SLOTS-1:0]    arb_req;
  logic                  arb_en;
  logic                  arb_adv;
  logic [N_SLOTS-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic [1:0]            grant_code;
  logic                  take;
  logic                  owner_wait;

  // The cycle after any ack is skipped so a slot still holding the consumed
  // coin is never granted twice.
  always_comb begin
    owner_mask = N_SLOTS'(1) << owner;
    arb_req    = owner_vld ? (coin_req & owner_mask) : coin_req;
    arb_en     = (state == IDLE) && (ack_q == '0) && (owner_vld || !sold_out);
    grant_code = coin_val[{grant_idx, 1'b0} +: 2];
    take       = |grant;
    arb_adv    = take && coin_valid(grant_code) && !owner_vld;
    owner_wait = (state == IDLE) && owner_vld && !coin_req[owner];
  end

  rr_arbiter #(
    .N(N_SLOTS)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (arb_req),
    .en   (arb_en),
    .adv  (arb_adv),
    .grant(grant),
    .idx  (grant_idx)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_vld  <= 1'b0;
      owner      <= '0;
      credit     <= '0;
      tmo_cnt    <= '0;
      ack_q      <= '0;
      rej_q      <= '0;
      vm_in      <= COIN_NONE;
      dispense   <= '0;
      change     <= '0;
      refund     <= '0;
      refund_amt <= '0;
      stock      <= STOCK_W'(STOCK_INIT);
      sold_out   <= (STOCK_INIT == 0);
    end else begin
      ack_q      <= '0;
      rej_q      <= '0;
      vm_in      <= COIN_NONE;
      dispense   <= '0;
      change     <= '0;
      refund     <= '0;
      refund_amt <= '0;
      sold_out   <= (stock == '0);

      case (state)
        IDLE: begin
          if (take) begin
            tmo_cnt <= '0;
            ack_q   <= grant;
            if (coin_valid(grant_code)) begin
              vm_in  <= grant_code;
              credit <= credit + coin_value(grant_code);
              state  <= ISSUE;
              if (!owner_vld) begin
                owner_vld <= 1'b1;
                owner     <= grant_idx;
              end
            end else begin
              rej_q <= grant;
            end
          end else if (owner_wait) begin
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
              state      <= ABORT;
              refund     <= owner_mask;
              refund_amt <= credit;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        ISSUE: state <= SETTLE;
        SETTLE: begin
          if (vm_out[VM_DISP]) begin
            dispense  <= owner_mask;
            change    <= vm_out[VM_CHG] ? owner_mask : '0;
            owner_vld <= 1'b0;
            credit    <= '0;
          end
          state <= IDLE;
        end
        ABORT: begin
          owner_vld <= 1'b0;
          credit    <= '0;
          tmo_cnt   <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A dispense reported with no stock is forwarded but never underflows.
      if (restock) begin
        stock <= STOCK_W'(STOCK_INIT);
      end else if (state == SETTLE && vm_out[VM_DISP] && stock != '0) begin
        stock <= stock - 1'b1;
      end
    end
  end

  assign vm_rst   = rst | (state == ABORT);
  assign coin_ack = ack_q & {N_SLOTS{~rst}};
  assign coin_rej = rej_q & {N_SLOTS{~rst}};

endmodule

// File: tb/tb_vend_coin_sched.sv
// Bench for vend_coin_sched: directed purchase scenarios plus random coin
// traffic, checked every cycle against a behavioural purchase model.
module tb_vend_coin_sched;

  localparam int N  = 4;
  localparam int SW = 8;
  localparam int SI = 10;
  localparam int TO = 16;

  localparam int P_IDLE   = 0;
  localparam int P_ISSUE  = 1;
  localparam int P_SETTLE = 2;
  localparam int P_ABORT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           restock = 1'b0;
  logic [N-1:0]   coin_req = '0;
  logic [2*N-1:0] coin_val = '0;
  logic [1:0]     vm_out;
  logic [N-1:0]   coin_ack, coin_rej, dispense, change, refund;
  logic [1:0]     vm_in, refund_amt;
  logic           vm_rst, sold_out;
  logic [SW-1:0]  stock;

  vend_coin_sched #(
    .N_SLOTS(N), .STOCK_W(SW), .STOCK_INIT(SI), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .coin_req(coin_req), .coin_val(coin_val),
    .restock(restock), .vm_out(vm_out), .coin_ack(coin_ack),
    .coin_rej(coin_rej), .vm_in(vm_in), .vm_rst(vm_rst),
    .dispense(dispense), .change(change), .refund(refund),
    .refund_amt(refund_amt), .stock(stock), .sold_out(sold_out)
  );

  // Stand-in for the 1.5-unit vending FSM: sums half units, reports
  // dispense at 3 or more, change at exactly 4, then clears.
  logic [2:0] fsm_sum;
  always @(posedge clk) begin
    if (vm_rst)              fsm_sum <= 3'd0;
    else if (vm_in == 2'b01) fsm_sum <= fsm_sum + 3'd1;
    else if (vm_in == 2'b10) fsm_sum <= fsm_sum + 3'd2;
    else if (fsm_sum >= 3)   fsm_sum <= 3'd0;
  end
  assign vm_out = {fsm_sum >= 3'd3, fsm_sum == 3'd4};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Coins waiting in each slot; the head is presented while the queue is non-empty.
  logic [1:0] coin_q [N][$];

  // Purchase model
  int           m_phase, m_owner, m_ptr, m_credit, m_idle, m_stock;
  bit           m_sold;
  logic [N-1:0] m_ack, m_rej, m_disp, m_chg, m_ref;
  logic [1:0]   m_vm_in, m_amt;

  // Observation counters for directed checks
  int n_ack [N];
  int n_rej [N];
  int n_disp[N];
  int n_chg [N];
  int n_ref [N];
  int n_issue, cyc, last_issue_cyc, disp_cyc, last_amt;
  int disp_order[$];

  task automatic model_step(input bit r, input logic [N-1:0] req,
                            input logic [2*N-1:0] val, input bit rs,
                            input logic [1:0] vo);
    logic [N-1:0] prev_ack;
    logic [1:0]   code;
    bit           next_sold;
    int           g;
    if (r) begin
      m_phase = P_IDLE; m_owner = -1; m_ptr = 0; m_credit = 0; m_idle = 0;
      m_stock = SI; m_sold = (SI == 0);
      m_ack = '0; m_rej = '0; m_disp = '0; m_chg = '0; m_ref = '0;
      m_vm_in = 2'b00; m_amt = 2'b00;
      return;
    end
    prev_ack = m_ack;
    m_ack = '0; m_rej = '0; m_disp = '0; m_chg = '0; m_ref = '0;
    m_vm_in = 2'b00; m_amt = 2'b00;
    next_sold = (m_stock == 0);
    case (m_phase)
      P_IDLE: begin
        g = -1;
        if (prev_ack == '0) begin
          if (m_owner >= 0) begin
            if (req[m_owner]) g = m_owner;
          end else if (!m_sold) begin
            for (int k = 0; k < N; k++)
              if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          end
        end
        if (g >= 0) begin
          m_idle   = 0;
          code     = val[2*g +: 2];
          m_ack[g] = 1'b1;
          if (code == 2'b01 || code == 2'b10) begin
            m_vm_in  = code;
            m_credit = m_credit + ((code == 2'b01) ? 1 : 2);
            if (m_owner < 0) begin
              m_owner = g;
              m_ptr   = (g + 1) % N;
            end
            m_phase = P_ISSUE;
          end else begin
            m_rej[g] = 1'b1;
          end
        end else if (m_owner >= 0 && !req[m_owner]) begin
          m_idle++;
          if (m_idle == TO) begin
            m_phase        = P_ABORT;
            m_ref[m_owner] = 1'b1;
            m_amt          = m_credit[1:0];
          end
        end
      end
      P_ISSUE: m_phase = P_SETTLE;
      P_SETTLE: begin
        if (vo[1]) begin
          m_disp[m_owner] = 1'b1;
          m_chg[m_owner]  = vo[0];
          if (m_stock > 0) m_stock--;
          m_credit = 0;
          m_owner  = -1;
        end
        m_phase = P_IDLE;
      end
      default: begin
        m_owner = -1; m_credit = 0; m_idle = 0; m_phase = P_IDLE;
      end
    endcase
    if (rs) m_stock = SI;
    m_sold = next_sold;
  endtask

  task automatic check_outputs(input bit r);
    check("coin_ack", coin_ack, m_ack);
    check("coin_rej", coin_rej, m_rej);
    check("vm_in", vm_in, m_vm_in);
    check("vm_rst", vm_rst, r || (m_phase == P_ABORT));
    check("dispense", dispense, m_disp);
    check("change", change, m_chg);
    check("refund", refund, m_ref);
    if (m_ref != '0) check("refund_amt", refund_amt, m_amt);
    check("stock", stock, m_stock);
    check("sold_out", sold_out, m_sold);
  endtask

  task automatic cycle(input bit r, input bit rs);
    logic [N-1:0]   s_req;
    logic [2*N-1:0] s_val;
    logic [1:0]     s_vo;
    @(negedge clk);
    rst     = r;
    restock = rs;
    for (int i = 0; i < N; i++) begin
      coin_req[i]        = (coin_q[i].size() > 0);
      coin_val[2*i +: 2] = (coin_q[i].size() > 0) ? coin_q[i][0] : 2'b00;
    end
    #1;
    s_req = coin_req;
    s_val = coin_val;
    s_vo  = vm_out;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, s_req, s_val, rs, s_vo);
    check_outputs(r);
    for (int i = 0; i < N; i++) begin
      if (coin_ack[i]) begin
        n_ack[i]++;
        if (coin_q[i].size() > 0) void'(coin_q[i].pop_front());
      end
      if (coin_rej[i]) n_rej[i]++;
      if (dispense[i]) begin
        n_disp[i]++;
        disp_order.push_back(i);
        disp_cyc = cyc;
      end
      if (change[i]) n_chg[i]++;
      if (refund[i]) begin
        n_ref[i]++;
        last_amt = refund_amt;
      end
    end
    if (vm_in != 2'b00) begin
      n_issue++;
      last_issue_cyc = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      n_ack[i] = 0; n_rej[i] = 0; n_disp[i] = 0; n_chg[i] = 0; n_ref[i] = 0;
    end
    n_issue = 0; last_amt = -1; last_issue_cyc = -100; disp_cyc = -1;
    disp_order.delete();
  endtask

  function automatic logic [1:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b11;
    return (r < 6) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    int waited;
    cyc = 0;
    clear_counts();

    // Reset state
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("reset_stock", stock, SI);
    check("reset_sold_out", sold_out, 1'b0);
    check("reset_vm_in", vm_in, 2'b00);

    // Three half coins from slot 0: exact price, no change
    clear_counts();
    coin_q[0].push_back(2'b01); coin_q[0].push_back(2'b01); coin_q[0].push_back(2'b01);
    run(14);
    check("a_issues", n_issue, 3);
    check("a_disp0", n_disp[0], 1);
    check("a_chg0", n_chg[0], 0);
    check("a_latency", disp_cyc - last_issue_cyc, 2);
    check("a_stock", stock, SI - 1);

    // Two one-unit coins from slot 2: dispense with change
    clear_counts();
    coin_q[2].push_back(2'b10); coin_q[2].push_back(2'b10);
    run(10);
    check("b_disp2", n_disp[2], 1);
    check("b_chg2", n_chg[2], 1);
    check("b_stock", stock, SI - 2);

    // Slots 1 and 3 contend from reset: slot 1 completes first
    cycle(1'b1, 1'b0);
    clear_counts();
    coin_q[1].push_back(2'b01); coin_q[1].push_back(2'b10);
    coin_q[3].push_back(2'b10); coin_q[3].push_back(2'b01);
    run(20);
    check("c_count", disp_order.size(), 2);
    if (disp_order.size() == 2) begin
      check("c_first", disp_order[0], 1);
      check("c_second", disp_order[1], 3);
    end
    check("c_stock", stock, SI - 2);

    // Slot 0 abandons after one half coin: refund of 1
    clear_counts();
    coin_q[0].push_back(2'b01);
    run(26);
    check("d_refund0", n_ref[0], 1);
    check("d_refund_amt", last_amt, 1);
    check("d_stock", stock, SI - 2);
    clear_counts();
    coin_q[0].push_back(2'b10); coin_q[0].push_back(2'b01);
    coin_q[2].push_back(2'b01); coin_q[2].push_back(2'b10);
    run(20);
    check("d_rr_count", disp_order.size(), 2);
    if (disp_order.size() == 2) begin
      check("d_rr_first", disp_order[0], 2);
      check("d_rr_second", disp_order[1], 0);
    end

    // Drain stock, confirm sold-out blocks grants until restock
    clear_counts();
    for (int i = 0; i < 2 * (SI - 4); i++) coin_q[1].push_back(2'b10);
    run(45);
    check("e_stock_empty", stock, 0);
    check("e_sold_out", sold_out, 1'b1);
    clear_counts();
    coin_q[3].push_back(2'b01);
    run(10);
    check("e_no_ack", n_ack[3], 0);
    cycle(1'b0, 1'b1);
    run(5);
    check("e_restock", stock, SI);
    check("e_not_sold", sold_out, 1'b0);
    check("e_ack_after", n_ack[3], 1);
    coin_q[3].push_back(2'b10);
    run(8);
    check("e_disp3", n_disp[3], 1);
    check("e_stock_after", stock, SI - 1);

    // Invalid codes rejected, then reset during SETTLE cancels the sale
    clear_counts();
    coin_q[1].push_back(2'b11); coin_q[1].push_back(2'b00);
    run(6);
    check("f_rej1", n_rej[1], 2);
    check("f_ack1", n_ack[1], 2);
    check("f_no_issue", n_issue, 0);
    clear_counts();
    coin_q[2].push_back(2'b10); coin_q[2].push_back(2'b10);
    waited = 0;
    while (n_issue < 2 && waited < 30) begin
      cycle(1'b0, 1'b0);
      waited++;
    end
    check("g_issue_seen", n_issue, 2);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("g_dispense_rst", dispense, '0);
    run(5);
    check("g_no_disp", n_disp[2], 0);
    check("g_no_refund", n_ref[2], 0);
    check("g_stock", stock, SI);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        int s;
        int cnt;
        s   = $urandom_range(0, N - 1);
        cnt = $urandom_range(1, 3);
        if (coin_q[s].size() < 4)
          for (int j = 0; j < cnt; j++) coin_q[s].push_back(rand_code());
      end
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
